// File: rtl/fifo_status.sv
// Occupancy and flag generator for a synchronous FIFO.
// Tracks the fill level from the accepted write/read strobes, decodes the
// empty/full and watermark flags from the next-state level so that every
// flag lines up with fifo_level, and keeps sticky overflow/underflow and
// pointer-consistency error flags.
module fifo_status #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned AF_THRESH  = 1020,
   parameter int unsigned AE_THRESH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  fifo_we,
   input  logic                  fifo_rd,
   input  logic [ADDR_WIDTH-1:0] wptr,
   input  logic [ADDR_WIDTH-1:0] rptr,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH:0]   fifo_level,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ptr_err
);

   localparam int unsigned LW    = ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0] LevelZero = '0;
   localparam logic [ADDR_WIDTH:0] LevelOne  = LW'(1);
   localparam logic [ADDR_WIDTH:0] LevelMax  = LW'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AeLevel   = LW'(AE_THRESH);
   localparam logic [ADDR_WIDTH:0] AfLevel   = LW'(AF_THRESH);

   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  at_full, at_empty;
   logic                  strobe_ovf, strobe_unf;
   logic                  ovf_set, unf_set, perr_set;
   logic                  overflow_d, underflow_d, ptr_err_d;
   logic                  rst_q;
   logic [ADDR_WIDTH-1:0] ptr_diff;
   logic                  ptr_mismatch;

   assign fifo_level = level_q;
   assign at_full    = (level_q == LevelMax);
   assign at_empty   = (level_q == LevelZero);

   // Next-state level with saturation at both ends; out-of-range strobes flag an error.
   always_comb begin
      level_d    = level_q;
      strobe_ovf = 1'b0;
      strobe_unf = 1'b0;
      unique case ({fifo_we, fifo_rd})
         2'b10: begin
            if (at_full) begin
               strobe_ovf = 1'b1;
            end else begin
               level_d = level_q + LevelOne;
            end
         end
         2'b01: begin
            if (at_empty) begin
               strobe_unf = 1'b1;
            end else begin
               level_d = level_q - LevelOne;
            end
         end
         2'b11: begin
            // Read of an empty FIFO: the write still lands, the read is an error.
            // When full, the pair cancels and is legal.
            if (at_empty) begin
               level_d    = LevelOne;
               strobe_unf = 1'b1;
            end
         end
         default: begin
            level_d = level_q;
         end
      endcase
   end

   // Pointer distance must equal the level modulo DEPTH (full and empty both give 0).
   always_comb begin
      ptr_diff     = wptr - rptr;
      ptr_mismatch = (ptr_diff != level_q[ADDR_WIDTH-1:0]);
   end

   // Sticky error next-state: a coincident set beats clr_err.
   always_comb begin
      ovf_set  = strobe_ovf | (wr & fifo_full);
      unf_set  = strobe_unf | (rd & fifo_empty);
      // rst_q masks the first cycle out of reset, before pointers and level have settled.
      perr_set = ptr_mismatch & ~rst_q;

      overflow_d  = overflow;
      underflow_d = underflow;
      ptr_err_d   = ptr_err;
      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         ptr_err_d   = 1'b0;
      end
      if (ovf_set) begin
         overflow_d = 1'b1;
      end
      if (unf_set) begin
         underflow_d = 1'b1;
      end
      if (perr_set) begin
         ptr_err_d = 1'b1;
      end
   end

   // Level, flags (decoded from next-state level) and sticky errors; rst overrides all.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q      <= LevelZero;
         fifo_empty   <= 1'b1;
         fifo_full    <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         ptr_err      <= 1'b0;
         rst_q        <= 1'b1;
      end else begin
         level_q      <= level_d;
         fifo_empty   <= (level_d == LevelZero);
         fifo_full    <= (level_d == LevelMax);
         almost_empty <= (level_d <= AeLevel);
         almost_full  <= (level_d >= AfLevel);
         overflow     <= overflow_d;
         underflow    <= underflow_d;
         ptr_err      <= ptr_err_d;
         rst_q        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status. The stimulus process sets the expected
// post-edge state for each cycle and pushes it to a scoreboard queue; a
// separate monitor pops one entry per falling edge and compares.
module tb_fifo_status;

   logic        clk = 1'b0;
   logic        rst, wr, rd, fifo_we, fifo_rd, clr_err;
   logic [9:0]  wptr, rptr;
   logic [10:0] fifo_level;
   logic        fifo_empty, fifo_full, almost_empty, almost_full;
   logic        overflow, underflow, ptr_err;

   fifo_status #(
      .ADDR_WIDTH(10),
      .AF_THRESH (1020),
      .AE_THRESH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr),
      .rd          (rd),
      .fifo_we     (fifo_we),
      .fifo_rd     (fifo_rd),
      .wptr        (wptr),
      .rptr        (rptr),
      .clr_err     (clr_err),
      .fifo_level  (fifo_level),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .almost_empty(almost_empty),
      .almost_full (almost_full),
      .overflow    (overflow),
      .underflow   (underflow),
      .ptr_err     (ptr_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] level;
      logic        empty;
      logic        full;
      logic        ae;
      logic        af;
      logic        ov;
      logic        un;
      logic        pe;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Expected state after the next edge, set by the stimulus before each tick.
   logic [10:0] e_level;
   logic        e_ov, e_un, e_pe;
   logic [9:0]  wp, rp;

   function automatic exp_t mk_exp();
      exp_t e;
      e.level = e_level;
      e.empty = (e_level == 11'd0);
      e.full  = (e_level == 11'd1024);
      e.ae    = (e_level <= 11'd4);
      e.af    = (e_level >= 11'd1020);
      e.ov    = e_ov;
      e.un    = e_un;
      e.pe    = e_pe;
      return e;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_lvl(input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL fifo_level: got %0d expected %0d at %0t", act, exp, $time);
      end
   endtask

   // Monitor: outputs are registered, so check them on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_lvl(fifo_level, e.level);
         chk1("fifo_empty", fifo_empty, e.empty);
         chk1("fifo_full", fifo_full, e.full);
         chk1("almost_empty", almost_empty, e.ae);
         chk1("almost_full", almost_full, e.af);
         chk1("overflow", overflow, e.ov);
         chk1("underflow", underflow, e.un);
         chk1("ptr_err", ptr_err, e.pe);
      end
   end

   task automatic drive(input logic wr_v, input logic rd_v, input logic we_v,
                        input logic frd_v, input logic clr_v);
      rst     = 1'b0;
      wr      = wr_v;
      rd      = rd_v;
      fifo_we = we_v;
      fifo_rd = frd_v;
      clr_err = clr_v;
      wptr    = wp;
      rptr    = rp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sb.push_back(mk_exp());
      @(negedge clk);
   endtask

   initial begin
      // Reset held two cycles with strobes active and inconsistent pointers.
      wp = 10'd0; rp = 10'd0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; wptr = 10'd7;
      e_level = 11'd0; e_ov = 1'b0; e_un = 1'b0; e_pe = 1'b0;
      tick();
      tick();
      // Release cycle: pointer check is masked even though wptr is off.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wptr = 10'd7;
      tick();

      // Fill to full.
      for (int i = 0; i < 1024; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         e_level = 11'(i + 1);
         tick();
         wp = wp + 10'd1;
      end
      // Write request while full sets overflow, level holds.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); e_ov = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      // Sticky clear, then clear racing a new set.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); e_ov = 1'b0; tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); e_ov = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); e_ov = 1'b0; tick();

      // Reset mid-operation from full, with a write strobe.
      wp = 10'd1000; rp = 10'd1000;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); rst = 1'b1;
      e_level = 11'd0; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

      // 29 writes: wptr 1000 -> 5, then drain with rptr wrapping.
      for (int i = 0; i < 29; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         e_level = 11'(i + 1);
         tick();
         wp = wp + 10'd1;
      end
      for (int i = 0; i < 29; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         e_level = 11'(28 - i);
         tick();
         rp = rp + 10'd1;
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); e_un = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); e_un = 1'b0; tick();

      // Simultaneous strobes at level 10.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         e_level = 11'(i + 1);
         tick();
         wp = wp + 10'd1;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         e_level = 11'd10;
         tick();
         wp = wp + 10'd1;
         rp = rp + 10'd1;
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         e_level = 11'(9 - i);
         tick();
         rp = rp + 10'd1;
      end
      // Both strobes while empty: write counts, underflow set.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      e_level = 11'd1; e_un = 1'b1; tick();
      wp = wp + 10'd1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); e_un = 1'b0; tick();

      // Pointer mismatch at level 3.
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         e_level = 11'(2 + i);
         tick();
         wp = wp + 10'd1;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wptr = rp + 10'd4;
      e_pe = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); e_pe = 1'b0; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

      // Let the monitor drain the scoreboard, bounded.
      for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
